// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write arbiter: FSM encoding and parameter defaults.
package fifo_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_LOCK   = 2'd3;

  function automatic logic st_can_accept(input logic [1:0] st);
    return (st == ST_IDLE) || (st == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first requester after LastGrant, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [$clog2(NUM_REQ)-1:0] LastGrant,
  output logic [NUM_REQ-1:0]         GrantOneHot,
  output logic [$clog2(NUM_REQ)-1:0] GrantIdx,
  output logic                       Any
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW:0]          start;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   hit;
  logic [IW:0]          offset;
  logic [IW:0]          idx_sum;
  logic [IW:0]          idx;

  // Rotate so bit 0 of req_rot is the requester right after LastGrant.
  assign start   = {1'b0, LastGrant} + (IW+1)'(1);
  assign req_dbl = {Req, Req} >> start;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_hit
      if (gi == 0) begin : g_first
        assign hit[gi] = req_rot[gi];
      end else begin : g_rest
        assign hit[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (hit[k]) offset = (IW+1)'(k);
    end
    idx_sum = start + offset;
    idx     = (idx_sum >= (IW+1)'(NUM_REQ)) ? idx_sum - (IW+1)'(NUM_REQ) : idx_sum;
  end

  assign Any         = |req_rot;
  assign GrantIdx    = Any ? idx[IW-1:0] : '0;
  assign GrantOneHot = Any ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin multi-requester write arbiter in front of an ECC-protected FIFO,
// with half-full throttling, an ECC error lockout and a saturating accept counter.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData,
  output logic [NUM_REQ-1:0]            ReqReady,
  input  logic                          Full_,
  input  logic                          HalfFull_,
  input  logic                          EccError,
  input  logic                          ErrClear,
  output logic                          WriteEn,
  output logic [DATA_WIDTH-1:0]         DataIn,
  output logic [$clog2(NUM_REQ)-1:0]    GrantId,
  output logic                          ErrLatched,
  output logic [CNT_WIDTH-1:0]          AcceptCount
);

  localparam int IW = $clog2(NUM_REQ);

  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] accept_count_q, accept_count_d;

  logic [NUM_REQ-1:0]    pick_oh;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  accept_ok;
  logic                  accept;
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = ReqData[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .Req         (ReqValid),
    .LastGrant   (last_grant_q),
    .GrantOneHot (pick_oh),
    .GrantIdx    (pick_idx),
    .Any         (pick_any)
  );

  // Reset gates the outputs combinationally so they drop in the same instant.
  always_comb begin
    accept_ok = ~Reset & Full_ & ~EccError & st_can_accept(state_q);
    accept    = accept_ok & pick_any;
    ReqReady  = accept_ok ? pick_oh : '0;
    WriteEn   = |(ReqValid & ReqReady);
    DataIn    = WriteEn ? req_word[pick_idx] : '0;
    GrantId   = WriteEn ? pick_idx : '0;
  end

  assign ErrLatched  = (state_q == ST_LOCK);
  assign AcceptCount = accept_count_q;

  always_comb begin
    state_d = state_q;
    if (EccError) begin
      state_d = ST_LOCK;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACTIVE: state_d = accept ? (HalfFull_ ? ST_ACTIVE : ST_GAP) : ST_IDLE;
        ST_GAP:             state_d = ST_IDLE;
        ST_LOCK:            state_d = ErrClear ? ST_IDLE : ST_LOCK;
        default:            state_d = ST_IDLE;
      endcase
    end

    last_grant_d   = accept ? pick_idx : last_grant_q;
    accept_count_d = accept_count_q;
    if (accept && (accept_count_q != '1)) accept_count_d = accept_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= IW'(NUM_REQ - 1);
      accept_count_q <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      accept_count_q <= accept_count_d;
    end
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one FIFO write word.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of accepted-word counter.
REQ-004 Clock  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 ReqValid  input  NUM_REQ  per-requester write request.
REQ-007 ReqData  input  NUM_REQ*DATA_WIDTH  requester words; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ReqReady  output  NUM_REQ  one-hot accept; handshake = ReqValid[i] & ReqReady[i].
REQ-009 Full_  input  1  FIFO full flag, active-low (0 = full).
REQ-010 HalfFull_  input  1  FIFO half-full flag, active-low (0 = at or above half).
REQ-011 EccError  input  1  OR of ECC decoder error outputs on the FIFO read side.
REQ-012 ErrClear  input  1  software clear of the error lockout.
REQ-013 WriteEn  output  1  FIFO write strobe.
REQ-014 DataIn  output  DATA_WIDTH  word to FIFO (pre-ECC-encode).
REQ-015 GrantId  output  clog2(NUM_REQ)  index of the current grant, valid when WriteEn=1.
REQ-016 ErrLatched  output  1  high while in lockout.
REQ-017 AcceptCount  output  CNT_WIDTH  saturating count of accepted words.

Function
REQ-018 FSM states: IDLE, ACTIVE, GAP, LOCK.
REQ-019 Accept allowed only in IDLE or ACTIVE, with Full_=1 and EccError=0; otherwise ReqReady = 0.
REQ-020 When allowed, the grant is the first i with ReqValid[i]=1, searching from LastGrant+1 modulo NUM_REQ (round-robin); ReqReady = one-hot of that i.
REQ-021 WriteEn = |(ReqValid & ReqReady) in the same cycle (zero latency); DataIn = ReqData slice of the grant; GrantId = grant index.
REQ-022 DataIn and GrantId SHALL be 0 when WriteEn=0.
REQ-023 LastGrant updates to the grant index only on an accept; holds otherwise.
REQ-024 IDLE/ACTIVE: accept with HalfFull_=0 -> GAP; accept with HalfFull_=1 -> ACTIVE; no accept -> IDLE.
REQ-025 GAP: no accept for exactly one cycle, then -> IDLE (throttle to at most 1 write per 2 cycles while half-full).
REQ-026 EccError=1 in any state -> LOCK next cycle; no accept in the EccError cycle.
REQ-027 LOCK: ReqReady=0, ErrLatched=1; ErrClear=1 with EccError=0 -> IDLE; ErrClear with EccError=1 stays in LOCK.
REQ-028 AcceptCount increments by 1 per accept, saturates at 2^CNT_WIDTH-1; never wraps.
REQ-029 Full_=0 blocks accepts in any state without a state change, except ACTIVE -> IDLE.
REQ-030 A requester deasserting ReqValid without a handshake SHALL lose nothing and SHALL not move LastGrant.

Reset
REQ-031 Reset=1 SHALL immediately force state IDLE, LastGrant = NUM_REQ-1 (first search starts at 0), AcceptCount=0, ErrLatched=0.
REQ-032 During Reset=1, ReqReady=0, WriteEn=0, DataIn=0, GrantId=0, regardless of inputs.
REQ-033 Reset asserted mid-LOCK or mid-GAP SHALL clear to IDLE with no pending write.

Structure
REQ-034 Shared package fifo_arb_pkg SHALL hold the state encoding (IDLE=0, ACTIVE=1, GAP=2, LOCK=3) and the NUM_REQ/DATA_WIDTH defaults.
REQ-035 Round-robin search SHALL be a sub-module rr_pick (inputs Req, LastGrant; outputs GrantOneHot, GrantIdx, Any), purely combinational.
REQ-036 All state (FSM, LastGrant, AcceptCount) SHALL be in fifo_wr_arb; no other registers.

Verification
REQ-037 After reset, ReqValid=4'b1111, Full_=1, HalfFull_=1 for 8 cycles -> GrantId sequence 0,1,2,3,0,1,2,3, AcceptCount=8.
REQ-038 ReqValid=4'b0101, HalfFull_=0 -> WriteEn pattern 1,0,1,0; GrantId 0,2,0,2 on write cycles.
REQ-039 Full_=0 for 3 cycles with ReqValid=4'b0010 -> ReqReady=0, WriteEn=0; Full_=1 -> accept requester 1 same cycle.
REQ-040 EccError pulse in an accept cycle -> no write that cycle, ErrLatched=1 next cycle; ErrClear -> IDLE, accepts resume.
REQ-041 CNT_WIDTH=4, 20 back-to-back accepts -> AcceptCount holds 15; Reset mid-stream -> all outputs 0 immediately.
REQ-042 Bench SHALL check every accepted DataIn against a per-requester scoreboard and end-to-end through the ECC-protected FIFO.
